// File: rtl/lfsr_seq_checker_if.sv
// Word-stream and status bundle between the LFSR word source and the sequence checker.
interface lfsr_seq_checker_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [11:0]      in_data;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic [CNT_W-1:0] err_count;

  modport master (
    output in_valid, in_data, clr_cnt,
    input  locked, err_pulse, err_count
  );

  modport slave (
    input  in_valid, in_data, clr_cnt,
    output locked, err_pulse, err_count
  );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for the 12-bit LFSR word stream: locks onto the sequence,
// predicts every next word and strobes/counts mispredictions while locked.
module lfsr_seq_checker #(
  parameter int LOCK_MATCHES  = 4,
  parameter int UNLOCK_MISSES = 3,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  lfsr_seq_checker_if.slave bus
);
  localparam int DATA_W = 12;
  localparam logic [3:0] LOCK_N   = 4'(LOCK_MATCHES);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_MISSES);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   prev, prev_nxt;
  logic                prev_vld, prev_vld_nxt;
  logic [3:0]          match_run, match_run_nxt;
  logic [3:0]          miss_run, miss_run_nxt;
  logic                err_pulse, err_pulse_nxt;
  logic [CNT_W-1:0]    err_count, err_count_nxt;
  logic                hit;
  logic [3:0]          match_inc, miss_inc;

  // The all-ones word is excluded from the shift sequence and folded onto zero, so 000/FFF chain in.
  function automatic logic [DATA_W-1:0] nxt(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    if (x == '0) return '1;
    y = {x[6] ^ x[4] ^ x[1] ^ x[0], x[DATA_W-1:1]};
    return (y == '1) ? '0 : y;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    state_nxt     = state;
    prev_nxt      = prev;
    prev_vld_nxt  = prev_vld;
    match_run_nxt = match_run;
    miss_run_nxt  = miss_run;
    err_pulse_nxt = 1'b0;
    err_count_nxt = err_count;
    hit           = (bus.in_data == nxt(prev));
    match_inc     = match_run + 4'd1;
    miss_inc      = miss_run + 4'd1;

    if (bus.in_valid) begin
      prev_nxt     = bus.in_data;
      prev_vld_nxt = 1'b1;
      case (state)
        HUNT: begin
          if (prev_vld) begin
            if (hit) begin
              match_run_nxt = match_inc;
              if (match_inc == LOCK_N) begin
                state_nxt     = LOCKED;
                match_run_nxt = '0;
                miss_run_nxt  = '0;
              end
            end else begin
              match_run_nxt = '0;
            end
          end
        end
        LOCKED: begin
          if (hit) begin
            miss_run_nxt = '0;
          end else begin
            err_pulse_nxt = 1'b1;
            err_count_nxt = sat_inc(err_count);
            miss_run_nxt  = miss_inc;
            if (miss_inc == UNLOCK_N) begin
              state_nxt     = HUNT;
              match_run_nxt = '0;
              miss_run_nxt  = '0;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end

    // Clear beats a same-cycle counted mismatch; the strobe is left alone.
    if (bus.clr_cnt) err_count_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= HUNT;
      prev      <= '0;
      prev_vld  <= 1'b0;
      match_run <= '0;
      miss_run  <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      prev_vld  <= prev_vld_nxt;
      match_run <= match_run_nxt;
      miss_run  <= miss_run_nxt;
      err_pulse <= err_pulse_nxt;
      err_count <= err_count_nxt;
    end
  end

  assign bus.locked    = (state == LOCKED);
  assign bus.err_pulse = err_pulse;
  assign bus.err_count = err_count;
endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker: vector table for lock/error/wrap/reset paths,
// plus hand-written saturation and clear-collision sequences.
module tb_lfsr_seq_checker;
  localparam int CW = 8;

  typedef struct {
    logic          rst_n;
    logic          vld;
    logic [11:0]   data;
    logic          clr;
    logic          l;
    logic          p;
    logic [CW-1:0] c;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  lfsr_seq_checker_if #(.CNT_W(CW)) bus ();

  lfsr_seq_checker #(
    .LOCK_MATCHES (4),
    .UNLOCK_MISSES(3),
    .CNT_W        (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] nxt(input logic [11:0] x);
    logic [11:0] y;
    if (x == 12'h000) return 12'hFFF;
    y = {x[6] ^ x[4] ^ x[1] ^ x[0], x[11:1]};
    return (y == 12'hFFF) ? 12'h000 : y;
  endfunction

  function automatic void add(input logic r, input logic v, input logic [11:0] d,
                              input logic cl, input logic l, input logic p, input int c);
    vec_t t;
    t.rst_n = r; t.vld = v; t.data = d; t.clr = cl;
    t.l = l; t.p = p; t.c = CW'(c);
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [11:0] d, input logic cl,
                      input logic l, input logic p, input logic [CW-1:0] c, input string name);
    @(negedge clk);
    rst_n        = r;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.clr_cnt  = cl;
    @(posedge clk);
    #1;
    chk({name, " locked"},    32'(bus.locked),    32'(l));
    chk({name, " err_pulse"}, 32'(bus.err_pulse), 32'(p));
    chk({name, " err_count"}, 32'(bus.err_count), 32'(c));
  endtask

  initial begin
    logic [11:0]   prev_m;
    logic [11:0]   w;
    logic [CW-1:0] cnt_m;

    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.clr_cnt  = 1'b0;

    // reset, including a valid word under reset
    add(0,0,12'h000,0, 0,0,0);
    add(0,1,12'h5A5,0, 0,0,0);
    // lock from reset on the 5th word
    add(1,1,12'h001,0, 0,0,0);
    add(1,1,12'h800,0, 0,0,0);
    add(1,1,12'h400,0, 0,0,0);
    add(1,1,12'h200,0, 0,0,0);
    add(1,1,12'h100,0, 1,0,0);
    add(1,1,12'h080,0, 1,0,0);
    add(1,1,12'h040,0, 1,0,0);
    // single mismatch while locked, gap, resync match
    add(1,1,12'h820,0, 1,0,0);
    add(1,1,12'h123,0, 1,1,1);
    add(1,0,12'h000,0, 1,0,1);
    add(1,1,12'h091,0, 1,0,1);
    // three consecutive misses unlock on the third
    add(1,1,12'h555,0, 1,1,2);
    add(1,1,12'h555,0, 1,1,3);
    add(1,1,12'h555,0, 0,1,4);
    add(1,0,12'h000,0, 0,0,4);
    // hunt: mismatch is silent, broken run restarts, then 4 matches relock
    add(1,1,12'h123,0, 0,0,4);
    add(1,1,12'h091,0, 0,0,4);
    add(1,1,12'h048,0, 0,0,4);
    add(1,1,12'h824,0, 0,0,4);
    add(1,1,12'h555,0, 0,0,4);
    add(1,1,12'hAAA,0, 0,0,4);
    add(1,1,12'hD55,0, 0,0,4);
    add(1,1,12'hEAA,0, 0,0,4);
    add(1,1,12'hF55,0, 1,0,4);
    // wrap through FFE,000,FFF,7FF while locked
    add(1,1,12'hFD6,0, 1,1,5);
    add(1,1,12'hFEB,0, 1,0,5);
    add(1,1,12'hFF5,0, 1,0,5);
    add(1,0,12'h000,0, 1,0,5);
    add(1,1,12'hFFA,0, 1,0,5);
    add(1,1,12'hFFD,0, 1,0,5);
    add(1,1,12'hFFE,0, 1,0,5);
    add(1,1,12'h000,0, 1,0,5);
    add(1,1,12'hFFF,0, 1,0,5);
    add(1,1,12'h7FF,0, 1,0,5);
    add(1,1,12'hFFE,0, 1,1,6);
    add(1,1,12'hFFF,0, 1,1,7);
    add(1,1,12'h7FF,0, 1,0,7);
    // reset mid-lock with valid high, then a gapped stream relocks
    add(0,1,12'h3FF,0, 0,0,0);
    add(1,1,12'h3FF,0, 0,0,0);
    add(1,0,12'h000,0, 0,0,0);
    add(1,1,12'h1FF,0, 0,0,0);
    add(1,0,12'h000,0, 0,0,0);
    add(1,1,12'h0FF,0, 0,0,0);
    add(1,1,12'h07F,0, 0,0,0);
    add(1,0,12'h000,0, 0,0,0);
    add(1,1,12'h03F,0, 1,0,0);

    foreach (vecs[i])
      step(vecs[i].rst_n, vecs[i].vld, vecs[i].data, vecs[i].clr,
           vecs[i].l, vecs[i].p, vecs[i].c, $sformatf("vec%0d", i));

    // saturation: miss, miss, match repeated past all-ones
    prev_m = 12'h03F;
    cnt_m  = '0;
    for (int g = 0; g < 132; g++) begin
      for (int k = 0; k < 2; k++) begin
        w      = nxt(prev_m) ^ 12'h5A5;
        cnt_m  = (&cnt_m) ? cnt_m : cnt_m + 1'b1;
        step(1, 1, w, 0, 1, 1, cnt_m, $sformatf("sat%0d_bad%0d", g, k));
        prev_m = w;
      end
      w      = nxt(prev_m);
      step(1, 1, w, 0, 1, 0, cnt_m, $sformatf("sat%0d_good", g));
      prev_m = w;
    end
    chk("sat_hold", 32'(bus.err_count), 32'({CW{1'b1}}));

    // clear together with a counted mismatch, then clear on an idle cycle
    w = nxt(prev_m) ^ 12'h00F;
    step(1, 1, w, 1, 1, 1, '0, "clr_collide");
    prev_m = w;
    w = nxt(prev_m) ^ 12'h00F;
    step(1, 1, w, 0, 1, 1, CW'(1), "after_clr_miss");
    prev_m = w;
    step(1, 0, 12'h000, 1, 1, 0, '0, "clr_idle");
    step(1, 1, nxt(prev_m), 0, 1, 0, '0, "clr_good");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
